// File: rtl/vend_pkg.sv
// Shared types for the change dispenser slice.
//   change_e      : coin-return request carried by one queue entry
//   disp_state_e  : dispenser FSM states
//   vend_req_t    : one queued request {vend, change}
//   encode_change : priority encoder doubledime > dime > nickel
//   first_change_state : FSM state that starts dispensing a given change request
package vend_pkg;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_N    = 2'd1,
    CH_D    = 2'd2,
    CH_DD   = 2'd3
  } change_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VEND  = 3'd1,
    ST_EJ_N  = 3'd2,
    ST_EJ_D1 = 3'd3,
    ST_EJ_D2 = 3'd4,
    ST_GAP   = 3'd5,
    ST_FAULT = 3'd6
  } disp_state_e;

  typedef struct packed {
    logic    vend;
    change_e change;
  } vend_req_t;

  function automatic change_e encode_change(input logic nickel, input logic dime,
                                            input logic doubledime);
    if (doubledime) return CH_DD;
    if (dime)       return CH_D;
    if (nickel)     return CH_N;
    return CH_NONE;
  endfunction

  // A doubledime is two dime ejections, so it starts in the same state as a dime.
  function automatic disp_state_e first_change_state(input change_e ch);
    case (ch)
      CH_N:       return ST_EJ_N;
      CH_D, CH_DD: return ST_EJ_D1;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/coin_req_fifo.sv
// Synchronous show-ahead FIFO of vend_req_t.
//   clock, reset : rising-edge clock, synchronous active-low reset (flushes the queue)
//   push, din    : write request; accepted when not full, or when full and popping this cycle
//   pop          : consume dout (ignored when empty)
//   dout         : head entry, valid whenever empty == 0
//   full, empty  : occupancy flags
module coin_req_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  vend_req_t din,
  output vend_req_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  vend_req_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every always_ff sees
  // the pre-edge values of its peers, independent of evaluation order.
  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues automatic_machine's one-cycle pulses and drives the
// vend motor and coin hoppers one action at a time with a done handshake.
//   clock, reset        : rising-edge clock, synchronous active-low reset
//   deliver, give_*     : one-cycle request pulses from the controller
//   vend / vend_done    : vend motor drive and its completion
//   eject_nickel, eject_dime / eject_done : hopper drives and coin-released strobe
//   busy     : FSM not idle or requests still queued
//   overflow : sticky, a request was dropped on a full queue
//   fault    : sticky, an actuator did not report done in time (exit via reset only)
module change_dispenser
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic deliver,
  input  logic give_nickel,
  input  logic give_dime,
  input  logic give_doubledime,
  output logic vend,
  input  logic vend_done,
  output logic eject_nickel,
  output logic eject_dime,
  input  logic eject_done,
  output logic busy,
  output logic overflow,
  output logic fault
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Capture encoder: any pulse yields one entry; deliver and change share it.
  vend_req_t req;
  logic      push;
  logic      pop;
  vend_req_t q_dout;
  logic      q_full;
  logic      q_empty;

  assign req.vend   = deliver;
  assign req.change = encode_change(give_nickel, give_dime, give_doubledime);
  assign push       = deliver | give_nickel | give_dime | give_doubledime;

  disp_state_e   state, state_nx;
  disp_state_e   gap_next, gap_next_nx;   // where GAP goes once its single cycle ends
  change_e       cur_change, cur_change_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          done_hit;

  assign pop = (state == ST_IDLE) && !q_empty;

  coin_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  // Each done input only counts in the state whose drive it answers.
  assign done_hit = ((state == ST_VEND) && vend_done) ||
                    (((state == ST_EJ_N) || (state == ST_EJ_D1) || (state == ST_EJ_D2))
                     && eject_done);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx      = state;
    gap_next_nx   = gap_next;
    cur_change_nx = cur_change;
    timer_nx      = timer;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          cur_change_nx = q_dout.change;
          state_nx      = q_dout.vend ? ST_VEND : first_change_state(q_dout.change);
          timer_nx      = '0;
        end
      end
      ST_VEND, ST_EJ_N, ST_EJ_D1, ST_EJ_D2: begin
        if (done_hit) begin
          state_nx = ST_GAP;
          case (state)
            ST_VEND:  gap_next_nx = first_change_state(cur_change);
            ST_EJ_D1: gap_next_nx = (cur_change == CH_DD) ? ST_EJ_D2 : ST_IDLE;
            default:  gap_next_nx = ST_IDLE;
          endcase
        end else if (timer == TIMER_LAST) begin
          state_nx = ST_FAULT;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      ST_GAP: begin
        state_nx = gap_next;
        timer_nx = '0;
      end
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      gap_next   <= ST_IDLE;
      cur_change <= CH_NONE;
      timer      <= '0;
      overflow   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      gap_next   <= gap_next_nx;
      cur_change <= cur_change_nx;
      timer      <= timer_nx;
      overflow   <= overflow | (push && q_full && !pop);
      fault      <= fault | (state_nx == ST_FAULT);
    end
  end

  // Drives decode the registered state, so they rise and fall on clock edges only.
  assign vend         = (state == ST_VEND);
  assign eject_nickel = (state == ST_EJ_N);
  assign eject_dime   = (state == ST_EJ_D1) || (state == ST_EJ_D2);
  assign busy         = (state != ST_IDLE) || !q_empty;

endmodule
